// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache frame layout and address split.
package cpu_types_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam int unsigned TAG_W_MAX = 30;
  localparam int unsigned IDX_W_MAX = 8;

  // One direct-mapped frame; tag is right-aligned, unused upper bits stay 0
  typedef struct packed {
    logic                 valid;
    logic [TAG_W_MAX-1:0] tag;
    logic [WORD_W-1:0]    data;
  } icache_frame_t;

  // Address split sized for the largest cache; idx/tag right-aligned
  typedef struct packed {
    logic [TAG_W_MAX-1:0] tag;
    logic [IDX_W_MAX-1:0] idx;
    logic [1:0]           bytoff;
  } icachef_t;

  // Split a byte address for a cache with idxw index bits
  function automatic icachef_t icache_split(input logic [WORD_W-1:0] addr,
                                            input int unsigned idxw);
    icachef_t s;
    s.bytoff = addr[1:0];
    s.idx    = IDX_W_MAX'((addr >> 2) & ((32'd1 << idxw) - 32'd1));
    s.tag    = TAG_W_MAX'(addr >> (idxw + 32'd2));
    return s;
  endfunction

endpackage

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with one-word frames.
// Hits are returned combinationally; a miss fetches one word from memory.
// Optional macro ICACHE_PERF_EN adds hit_count / miss_count outputs.
module icache
  import cpu_types_pkg::*;
#(
  parameter int unsigned FRAMES = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        iwait,
  input  logic [31:0] iload,
  output logic        iREN,
  output logic [31:0] iaddr
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`endif
);

  localparam int unsigned IDXW = $clog2(FRAMES);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t        state;
  logic [31:0]   missaddr;
  icache_frame_t frames [FRAMES];

  icachef_t        cur;
  icachef_t        mis;
  logic [IDXW-1:0] cur_idx;
  logic [IDXW-1:0] mis_idx;
  icache_frame_t   cur_frame;
  logic            hit;

  // Address decode for the live request and the latched miss
  assign cur       = icache_split(imemaddr, IDXW);
  assign mis       = icache_split(missaddr, IDXW);
  assign cur_idx   = IDXW'(cur.idx);
  assign mis_idx   = IDXW'(mis.idx);
  assign cur_frame = frames[cur_idx];

  // Lookup is only honoured in IDLE so FETCH never reports a hit
  assign hit      = (state == IDLE) && imemREN && cur_frame.valid &&
                    (cur_frame.tag == cur.tag);
  assign ihit     = hit;
  assign imemload = hit ? cur_frame.data : 32'd0;
  assign iREN     = (state == FETCH);
  assign iaddr    = (state == FETCH) ? missaddr : 32'd0;

  // Byte offset and spare index bits carry no information here
  logic unused_bits;
  assign unused_bits = ^{cur.bytoff, mis.bytoff, cur.idx, mis.idx};

  // FSM, miss-address latch, frame fill and optional event counters
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      missaddr <= 32'd0;
      for (int i = 0; i < int'(FRAMES); i++) begin
        frames[i] <= '0;
      end
`ifdef ICACHE_PERF_EN
      hit_count  <= 32'd0;
      miss_count <= 32'd0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (imemREN && !hit) begin
            missaddr <= imemaddr;
            state    <= FETCH;
`ifdef ICACHE_PERF_EN
            miss_count <= miss_count + 32'd1;
`endif
          end
`ifdef ICACHE_PERF_EN
          if (hit) begin
            hit_count <= hit_count + 32'd1;
          end
`endif
        end
        FETCH: begin
          // Fill always completes to the latched address, even after a redirect
          if (!iwait) begin
            frames[mis_idx] <= '{valid: 1'b1, tag: mis.tag, data: iload};
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache (FRAMES = 16).
module tb_icache;

  logic        CLK;
  logic        nRST;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic        ihit;
  logic [31:0] imemload;
  logic        iwait;
  logic [31:0] iload;
  logic        iREN;
  logic [31:0] iaddr;
`ifdef ICACHE_PERF_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  icache #(.FRAMES(16)) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .imemREN  (imemREN),
    .imemaddr (imemaddr),
    .ihit     (ihit),
    .imemload (imemload),
    .iwait    (iwait),
    .iload    (iload),
    .iREN     (iREN),
    .iaddr    (iaddr)
`ifdef ICACHE_PERF_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Advance one cycle; inputs are driven just after the rising edge
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset();
    nRST = 1'b0; imemREN = 1'b1; imemaddr = 32'h4; iwait = 1'b1; iload = 32'hDEAD_BEEF;
    cyc(); cyc();
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL reset_ihit: got %0b want 0", ihit); end
    n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL reset_iREN: got %0b want 0", iREN); end
    n_checks++; if (iaddr !== 32'h0) begin n_fail++; $display("FAIL reset_iaddr: got %h want 0", iaddr); end
    n_checks++; if (imemload !== 32'h0) begin n_fail++; $display("FAIL reset_imemload: got %h want 0", imemload); end
    nRST = 1'b1;
    #1;
  endtask

  task automatic test_cold_miss();
    imemREN = 1'b1; imemaddr = 32'h4; iwait = 1'b1; iload = 32'h0;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL cold_idle_ihit: got %0b want 0", ihit); end
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) begin iwait = 1'b0; iload = 32'h2001_0005; end
      #1;
      n_checks++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL cold_fetch_iREN[%0d]: got %0b want 1", i, iREN); end
      n_checks++; if (iaddr !== 32'h4) begin n_fail++; $display("FAIL cold_fetch_iaddr[%0d]: got %h want 4", i, iaddr); end
      n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL cold_fetch_ihit[%0d]: got %0b want 0", i, ihit); end
    end
    cyc();
    iwait = 1'b1; iload = 32'h0;
    #1;
    n_checks++; if (ihit !== 1'b1) begin n_fail++; $display("FAIL cold_done_ihit: got %0b want 1", ihit); end
    n_checks++; if (imemload !== 32'h2001_0005) begin n_fail++; $display("FAIL cold_done_data: got %h want 20010005", imemload); end
    n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL cold_done_iREN: got %0b want 0", iREN); end
  endtask

  task automatic test_warm_hit();
    cyc();
    n_checks++; if (ihit !== 1'b1) begin n_fail++; $display("FAIL warm_ihit: got %0b want 1", ihit); end
    n_checks++; if (imemload !== 32'h2001_0005) begin n_fail++; $display("FAIL warm_data: got %h want 20010005", imemload); end
    n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL warm_iREN: got %0b want 0", iREN); end
    imemREN = 1'b0;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL noreq_ihit: got %0b want 0", ihit); end
    n_checks++; if (imemload !== 32'h0) begin n_fail++; $display("FAIL noreq_imemload: got %h want 0", imemload); end
    cyc();
    n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL noreq_stay_idle: iREN got %0b want 0", iREN); end
    imemREN = 1'b1;
  endtask

  task automatic test_conflict();
    imemaddr = 32'h44;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL conflict_miss44: got %0b want 0", ihit); end
    cyc();
    iwait = 1'b0; iload = 32'hAAAA_0044;
    #1;
    n_checks++; if (iaddr !== 32'h44) begin n_fail++; $display("FAIL conflict_iaddr44: got %h want 44", iaddr); end
    cyc();
    iwait = 1'b1;
    #1;
    n_checks++; if (imemload !== 32'hAAAA_0044) begin n_fail++; $display("FAIL conflict_data44: got %h want aaaa0044", imemload); end
    imemaddr = 32'h4;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL conflict_evicted4: got %0b want 0", ihit); end
    cyc();
    iwait = 1'b0; iload = 32'h2001_0005;
    #1;
    n_checks++; if (iaddr !== 32'h4) begin n_fail++; $display("FAIL conflict_refetch4: got %h want 4", iaddr); end
    cyc();
    iwait = 1'b1;
    #1;
    n_checks++; if (imemload !== 32'h2001_0005) begin n_fail++; $display("FAIL conflict_data4: got %h want 20010005", imemload); end
  endtask

  task automatic test_redirect();
    imemaddr = 32'h8;
    cyc();
    imemaddr = 32'h100;
    #1;
    n_checks++; if (iaddr !== 32'h8) begin n_fail++; $display("FAIL redirect_iaddr: got %h want 8", iaddr); end
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL redirect_fetch_ihit: got %0b want 0", ihit); end
    iwait = 1'b0; iload = 32'h8888_0008;
    cyc();
    iwait = 1'b1;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL redirect_miss100: got %0b want 0", ihit); end
    cyc();
    n_checks++; if (iaddr !== 32'h100) begin n_fail++; $display("FAIL redirect_iaddr100: got %h want 100", iaddr); end
    iwait = 1'b0; iload = 32'h1111_0100;
    cyc();
    iwait = 1'b1;
    #1;
    n_checks++; if (imemload !== 32'h1111_0100) begin n_fail++; $display("FAIL redirect_data100: got %h want 11110100", imemload); end
    imemaddr = 32'h8;
    #1;
    n_checks++; if (imemload !== 32'h8888_0008) begin n_fail++; $display("FAIL redirect_frame2: got %h want 88880008", imemload); end
  endtask

  task automatic test_reset_mid_fetch();
    imemaddr = 32'hC;
    cyc();
    n_checks++; if (iREN !== 1'b1) begin n_fail++; $display("FAIL rstfetch_pre_iREN: got %0b want 1", iREN); end
    #1;
    nRST = 1'b0;
    #1;
    n_checks++; if (iREN !== 1'b0) begin n_fail++; $display("FAIL rstfetch_iREN_async: got %0b want 0", iREN); end
    n_checks++; if (iaddr !== 32'h0) begin n_fail++; $display("FAIL rstfetch_iaddr: got %h want 0", iaddr); end
    cyc();
    nRST = 1'b1;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL rstfetch_remiss: got %0b want 0", ihit); end
    cyc();
    n_checks++; if (iaddr !== 32'hC) begin n_fail++; $display("FAIL rstfetch_refetch: got %h want c", iaddr); end
    iwait = 1'b0; iload = 32'hCCCC_000C;
    cyc();
    iwait = 1'b1;
    imemaddr = 32'h8;
    #1;
    n_checks++; if (ihit !== 1'b0) begin n_fail++; $display("FAIL rstfetch_wiped8: got %0b want 0", ihit); end
    imemREN = 1'b0;
    cyc();
  endtask

`ifdef ICACHE_PERF_EN
  task automatic test_perf();
    logic [31:0] addrs [5];
    addrs[0] = 32'h10; addrs[1] = 32'h14; addrs[2] = 32'h18; addrs[3] = 32'h10; addrs[4] = 32'h14;
    nRST = 1'b0; imemREN = 1'b0; iwait = 1'b1;
    cyc();
    nRST = 1'b1;
    #1;
    n_checks++; if (hit_count !== 32'd0) begin n_fail++; $display("FAIL perf_reset_hits: got %0d want 0", hit_count); end
    n_checks++; if (miss_count !== 32'd0) begin n_fail++; $display("FAIL perf_reset_misses: got %0d want 0", miss_count); end
    imemREN = 1'b1;
    for (int i = 0; i < 3; i++) begin
      imemaddr = addrs[i];
      cyc();
      iwait = 1'b0; iload = 32'h5000_0000 + addrs[i];
      cyc();
      iwait = 1'b1;
    end
    for (int i = 0; i < 5; i++) begin
      imemaddr = addrs[i];
      cyc();
    end
    imemREN = 1'b0;
    cyc();
    n_checks++; if (miss_count !== 32'd3) begin n_fail++; $display("FAIL perf_misses: got %0d want 3", miss_count); end
    n_checks++; if (hit_count !== 32'd5) begin n_fail++; $display("FAIL perf_hits: got %0d want 5", hit_count); end
  endtask
`endif

  initial begin
    test_reset();
    test_cold_miss();
    test_warm_hit();
    test_conflict();
    test_redirect();
    test_reset_mid_fetch();
`ifdef ICACHE_PERF_EN
    test_perf();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
